// File: rtl/subleq_sequencer.sv
// SUBLEQ execution sequencer: fetches three operand words, reads both operands,
// writes B-A back to B and branches to C when the result is <= 0.
module subleq_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam int DATA_W = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_A = 3'd1;
  localparam logic [2:0] FETCH_B = 3'd2;
  localparam logic [2:0] FETCH_C = 3'd3;
  localparam logic [2:0] READ_A  = 3'd4;
  localparam logic [2:0] READ_B  = 3'd5;
  localparam logic [2:0] WRITE_B = 3'd6;
  localparam logic [2:0] HALT    = 3'd7;

  logic [2:0]               state;
  logic [DATA_W-1:0]        op_a;
  logic [DATA_W-1:0]        op_b;
  logic [DATA_W-1:0]        op_c;
  logic signed [DATA_W-1:0] val_a;
  logic signed [DATA_W-1:0] val_b;
  logic signed [DATA_W-1:0] res;
  logic                     leq;

  // Two's complement difference, wrapping silently on overflow.
  function automatic logic signed [DATA_W-1:0] sub_wrap(
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] a
  );
    return b - a;
  endfunction

  function automatic logic is_leq(input logic signed [DATA_W-1:0] r);
    return r[DATA_W-1] | (r == '0);
  endfunction

  assign res    = sub_wrap(val_b, val_a);
  assign leq    = is_leq(res);
  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

  // Bus is a pure decode of state, so reset drops mem_we without waiting for a clock.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      FETCH_A: begin mem_addr = pc;          mem_re = 1'b1; end
      FETCH_B: begin mem_addr = pc + 16'd1;  mem_re = 1'b1; end
      FETCH_C: begin mem_addr = pc + 16'd2;  mem_re = 1'b1; end
      READ_A:  begin mem_addr = op_a;        mem_re = 1'b1; end
      READ_B:  begin mem_addr = op_b;        mem_re = 1'b1; end
      WRITE_B: begin
        mem_addr  = op_b;
        mem_we    = 1'b1;
        mem_wdata = res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_count <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      val_a       <= '0;
      val_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            instr_count <= '0;
            state       <= FETCH_A;
          end
        end
        HALT: begin
          if (start) begin
            pc          <= RESET_PC;
            instr_count <= '0;
            state       <= FETCH_A;
          end
        end
        FETCH_A: begin op_a  <= mem_rdata; state <= FETCH_B; end
        FETCH_B: begin op_b  <= mem_rdata; state <= FETCH_C; end
        FETCH_C: begin op_c  <= mem_rdata; state <= READ_A;  end
        READ_A:  begin val_a <= mem_rdata; state <= READ_B;  end
        READ_B:  begin val_b <= mem_rdata; state <= WRITE_B; end
        WRITE_B: begin
          instr_count <= instr_count + 16'd1;
          if (leq) begin
            pc    <= op_c;
            state <= op_c[DATA_W-1] ? HALT : FETCH_A;
          end else begin
            pc    <= pc + 16'd3;
            state <= FETCH_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer: two DUTs (default and FFFE reset pc), each
// with a 1K-word behavioural memory decoding the low 10 address bits.
module tb_subleq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [15:0] addr0, wdata0, rdata0, pc0, cnt0;
  logic        we0, re0, busy0, halted0;
  logic [15:0] addr1, wdata1, rdata1, pc1, cnt1;
  logic        we1, re1, busy1, halted1;

  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subleq_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0), .mem_re(re0),
    .mem_rdata(rdata0), .pc(pc0), .busy(busy0), .halted(halted0),
    .instr_count(cnt0)
  );

  subleq_sequencer #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .mem_re(re1),
    .mem_rdata(rdata1), .pc(pc1), .busy(busy1), .halted(halted1),
    .instr_count(cnt1)
  );

  assign rdata0 = re0 ? mem0[addr0[9:0]] : 16'h0000;
  assign rdata1 = re1 ? mem1[addr1[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (we0) mem0[addr0[9:0]] <= wdata0;
    if (we1) mem1[addr1[9:0]] <= wdata1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_halt0(input string tag, input int max);
    int n = 0;
    while (!halted0 && n < max) begin
      tick();
      n++;
    end
    check(tag, halted0, 1'b1);
  endtask

  logic [15:0] exp_trace [12] = '{16'd0, 16'd1, 16'd2, 16'd6, 16'd7, 16'd7,
                                  16'd3, 16'd4, 16'd5, 16'd8, 16'd8, 16'd8};

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    tick(2);
    rst_n = 1'b1;
    tick();

    // Two-instruction program from IDLE
    mem0[0] = 16'd6; mem0[1] = 16'd7; mem0[2] = 16'd3;
    mem0[3] = 16'd8; mem0[4] = 16'd8; mem0[5] = 16'hFFFF;
    mem0[6] = 16'd5; mem0[7] = 16'd7; mem0[8] = 16'd9;
    check("idle_busy", busy0, 1'b0);
    check("idle_pc", pc0, 16'h0000);
    pulse_start0();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("trace%0d", i), addr0, exp_trace[i]);
      if (i == 5) begin
        check("wb1_we", we0, 1'b1);
        check("wb1_wdata", wdata0, 16'd2);
      end
      if (i == 11) check("wb2_wdata", wdata0, 16'd0);
      tick();
      if (i == 5) begin
        check("mem7", mem0[7], 16'd2);
        check("pc_after1", pc0, 16'd3);
        check("cnt_after1", cnt0, 16'd1);
        check("busy_after1", busy0, 1'b1);
      end
    end
    check("mem8", mem0[8], 16'd0);
    check("halted", halted0, 1'b1);
    check("busy_halt", busy0, 1'b0);
    check("pc_halt", pc0, 16'hFFFF);
    check("cnt_halt", cnt0, 16'd2);
    check("halt_re", re0, 1'b0);

    // Restart from HALT, then reset asynchronously mid-WRITE_B of the 2nd instruction
    pulse_start0();
    tick(11);
    check("pre_rst_we", we0, 1'b1);
    check("pre_rst_addr", addr0, 16'd8);
    check("pre_rst_pc", pc0, 16'd3);
    check("pre_rst_cnt", cnt0, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_we", we0, 1'b0);
    check("rst_re", re0, 1'b0);
    check("rst_pc", pc0, 16'h0000);
    check("rst_busy", busy0, 1'b0);
    check("rst_halted", halted0, 1'b0);
    check("rst_cnt", cnt0, 16'd0);
    check("rst_wrap_pc", pc1, 16'hFFFE);
    tick(2);
    check("rst_hold_busy", busy0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Negative-result branch
    mem0[0] = 16'h20; mem0[1] = 16'h21; mem0[2] = 16'h10;
    mem0[16'h20] = 16'd3; mem0[16'h21] = 16'd1;
    mem0[16'h10] = 16'h22; mem0[16'h11] = 16'h22; mem0[16'h12] = 16'hFFFF;
    mem0[16'h22] = 16'h0;
    pulse_start0();
    tick(5);
    check("neg_wdata", wdata0, 16'hFFFE);
    tick();
    check("neg_memB", mem0[16'h21], 16'hFFFE);
    check("neg_fetch", addr0, 16'h0010);
    check("neg_fetch_re", re0, 1'b1);
    check("neg_not_halt", halted0, 1'b0);
    wait_halt0("neg_halt", 20);

    // Wrapping subtraction: 1 - 8000 = 8001, branch taken
    mem0[0] = 16'h30; mem0[1] = 16'h31; mem0[2] = 16'h40;
    mem0[16'h30] = 16'h8000; mem0[16'h31] = 16'h0001;
    mem0[16'h40] = 16'h22; mem0[16'h41] = 16'h22; mem0[16'h42] = 16'hFFFF;
    pulse_start0();
    tick(5);
    check("wrap2_wdata", wdata0, 16'h8001);
    tick();
    check("wrap2_pc", pc0, 16'h0040);
    check("wrap2_mem", mem0[16'h31], 16'h8001);
    wait_halt0("wrap2_halt", 20);

    // start held high across a whole run and into HALT
    mem0[0] = 16'h50; mem0[1] = 16'h51; mem0[2] = 16'd3;
    mem0[3] = 16'h52; mem0[4] = 16'h52; mem0[5] = 16'hFFFF;
    mem0[16'h50] = 16'd1; mem0[16'h51] = 16'd1; mem0[16'h52] = 16'd0;
    start0 = 1'b1;
    tick();
    tick(6);
    check("hold_addr", addr0, 16'd3);
    check("hold_cnt", cnt0, 16'd1);
    tick(6);
    check("hold_halted", halted0, 1'b1);
    check("hold_cnt2", cnt0, 16'd2);
    tick();
    check("restart_busy", busy0, 1'b1);
    check("restart_addr", addr0, 16'h0000);
    check("restart_pc", pc0, 16'h0000);
    check("restart_cnt", cnt0, 16'd0);
    start0 = 1'b0;
    wait_halt0("restart_halt", 20);

    // Self-modifying: instruction 0 writes the C word of instruction 1
    mem0[0] = 16'h60; mem0[1] = 16'd5; mem0[2] = 16'd3;
    mem0[3] = 16'h62; mem0[4] = 16'h62; mem0[5] = 16'h0010;
    mem0[16'h60] = 16'h0011; mem0[16'h62] = 16'h0;
    pulse_start0();
    tick(8);
    check("smc_addr", addr0, 16'd5);
    check("smc_rdata", rdata0, 16'hFFFF);
    wait_halt0("smc_halt", 20);
    check("smc_pc", pc0, 16'hFFFF);
    check("smc_cnt", cnt0, 16'd2);

    // Program counter wrap with RESET_PC = FFFE
    mem1[10'h3FE] = 16'h10; mem1[10'h3FF] = 16'h11; mem1[0] = 16'h20;
    mem1[16'h10] = 16'd1; mem1[16'h11] = 16'd5;
    mem1[1] = 16'h12; mem1[2] = 16'h12; mem1[3] = 16'hFFFF; mem1[16'h12] = 16'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("wrap1_f0", addr1, 16'hFFFE);
    tick();
    check("wrap1_f1", addr1, 16'hFFFF);
    tick();
    check("wrap1_f2", addr1, 16'h0000);
    tick(3);
    check("wrap1_wdata", wdata1, 16'd4);
    tick();
    check("wrap1_pc", pc1, 16'h0001);
    check("wrap1_not_halt", halted1, 1'b0);
    for (int n = 0; n < 20 && !halted1; n++) tick();
    check("wrap1_halt", halted1, 1'b1);
    check("wrap1_pc_halt", pc1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
